// File: rtl/bldc_pwm_commutator_if.sv
// Controller-side bundle for the BLDC commutator: duty/enable/hall in,
// gate drives and status out.
interface bldc_pwm_commutator_if;
    logic               enable;
    logic signed [23:0] duty;
    logic [2:0]         hall;
    logic [5:0]         gates;
    logic               pwm_out;
    logic               period_start;
    logic               hall_fault;

    modport master (
        output enable, duty, hall,
        input  gates, pwm_out, period_start, hall_fault
    );

    modport slave (
        input  enable, duty, hall,
        output gates, pwm_out, period_start, hall_fault
    );
endinterface

// File: rtl/bldc_pwm_commutator.sv
// Six-step BLDC commutator: PWM from |duty|, direction from its sign,
// Hall-driven phase selection with dead time on every pair change.
module bldc_pwm_commutator #(
    parameter int unsigned PERIOD   = 1000,
    parameter int unsigned DEADTIME = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic CLK,
    input  logic reset,
    bldc_pwm_commutator_if.slave bus
);

    localparam int unsigned DATA_W = 24;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
    localparam logic [7:0] DT_LOAD = 8'(DEADTIME - 1);

    // |duty| clamped to one full period; -2^23 negates to 2^23 as unsigned.
    function automatic logic [CNT_W-1:0] sat_mag(input logic signed [DATA_W-1:0] d);
        logic [DATA_W-1:0] a;
        a = d[DATA_W-1] ? DATA_W'(-d) : DATA_W'(d);
        if (32'(a) >= PERIOD) return CNT_W'(PERIOD);
        return CNT_W'(a);
    endfunction

    // Pair code {valid, high phase, low phase}; phases 0=A, 1=B, 2=C.
    function automatic logic [4:0] select_pair(input logic [2:0] h, input logic rev);
        logic [1:0] hi;
        logic [1:0] lo;
        hi = 2'd0;
        lo = 2'd0;
        case (h)
            3'b101: begin hi = 2'd0; lo = 2'd1; end
            3'b100: begin hi = 2'd0; lo = 2'd2; end
            3'b110: begin hi = 2'd1; lo = 2'd2; end
            3'b010: begin hi = 2'd1; lo = 2'd0; end
            3'b011: begin hi = 2'd2; lo = 2'd0; end
            3'b001: begin hi = 2'd2; lo = 2'd1; end
            default: return 5'd0;
        endcase
        if (rev) return {1'b1, lo, hi};
        return {1'b1, hi, lo};
    endfunction

    function automatic logic [5:0] drive(input logic [4:0] pair, input logic pwm, input logic on);
        logic [5:0] g;
        g = 6'd0;
        if (!pair[4]) return g;
        case (pair[3:2])
            2'd0:    g[5] = pwm;
            2'd1:    g[3] = pwm;
            default: g[1] = pwm;
        endcase
        case (pair[1:0])
            2'd0:    g[4] = on;
            2'd1:    g[2] = on;
            default: g[0] = on;
        endcase
        return g;
    endfunction

    logic [CNT_W-1:0] cnt_p0;
    logic [CNT_W-1:0] mag_p0;
    logic             dir_p0;
    logic [2:0]       hall_p0;
    logic [2:0]       hall_p1;
    logic [4:0]       pair_p1;
    logic [7:0]       dt_p1;
    logic [5:0]       gates_p1;
    logic             pwm_p1;
    logic             start_p1;
    logic             fault_p1;

    logic             h_ok;
    logic             pwm_n;
    logic [4:0]       tgt;

    always_comb begin
        h_ok  = (hall_p1 != 3'b000) && (hall_p1 != 3'b111);
        pwm_n = bus.enable && (cnt_p0 < mag_p0);
        tgt   = (bus.enable && h_ok) ? select_pair(hall_p1, dir_p0) : 5'd0;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cnt_p0   <= '0;
            mag_p0   <= '0;
            dir_p0   <= 1'b0;
            hall_p0  <= 3'd0;
            hall_p1  <= 3'd0;
            pair_p1  <= 5'd0;
            dt_p1    <= 8'd0;
            gates_p1 <= 6'd0;
            pwm_p1   <= 1'b0;
            start_p1 <= 1'b0;
            fault_p1 <= 1'b0;
        end else begin
            // stage 0: hall synchronizer, period counter, duty latch
            hall_p0 <= bus.hall;
            hall_p1 <= hall_p0;
            if (!bus.enable || cnt_p0 == LAST) cnt_p0 <= '0;
            else                               cnt_p0 <= cnt_p0 + 1'b1;
            if (!bus.enable || cnt_p0 == LAST) begin
                mag_p0 <= sat_mag(bus.duty);
                dir_p0 <= bus.duty[DATA_W-1];
            end
            // stage 1: registered outputs and dead-time sequencing
            pwm_p1   <= pwm_n;
            start_p1 <= bus.enable && (cnt_p0 == '0);
            fault_p1 <= !h_ok;
            if (tgt != pair_p1) begin
                pair_p1  <= tgt;
                dt_p1    <= DT_LOAD;
                gates_p1 <= 6'd0;
            end else if (dt_p1 != 8'd0) begin
                dt_p1    <= dt_p1 - 1'b1;
                gates_p1 <= 6'd0;
            end else begin
                gates_p1 <= drive(pair_p1, pwm_n, mag_p0 != '0);
            end
        end
    end

    assign bus.gates        = gates_p1;
    assign bus.pwm_out      = pwm_p1;
    assign bus.period_start = start_p1;
    assign bus.hall_fault   = fault_p1;

endmodule

// File: tb/tb_bldc_pwm_commutator.sv
// Randomized scoreboard bench for bldc_pwm_commutator against a
// cycle-indexed behavioural model of the commutation rules.
module tb_bldc_pwm_commutator;

    localparam int P  = 200;
    localparam int DT = 8;

    typedef struct packed {
        logic [5:0] gates;
        logic       pwm;
        logic       ps;
        logic       hf;
    } exp_t;

    logic CLK;
    logic reset;
    bldc_pwm_commutator_if bus();

    bldc_pwm_commutator #(.PERIOD(P), .DEADTIME(DT), .CNT_W(16)) dut (
        .CLK(CLK),
        .reset(reset),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model state: position within period, latched magnitude/direction,
    // the two hall samples in flight, the targeted pair and when it was chosen.
    int m_pos, m_mag, m_dir, m_s1, m_s2, m_hi, m_lo, m_t, m_change_t;
    int hi_tbl[8] = '{-1, 2, 1, 2, 0, 0, 1, -1};
    int lo_tbl[8] = '{-1, 1, 0, 0, 2, 1, 2, -1};

    function automatic logic [5:0] pattern(int hi, int lo, bit pwm, bit on);
        logic [5:0] g;
        g = 6'd0;
        if (pwm) g = g | (6'b1 << (5 - 2 * hi));
        if (on)  g = g | (6'b1 << (4 - 2 * lo));
        return g;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_mag = 0; m_dir = 0; m_s1 = 0; m_s2 = 0;
        m_hi = -1; m_lo = -1; m_change_t = -100000;
    endtask

    task automatic model_step(input bit r, input bit e, input int d, input int h, output exp_t o);
        int  thi, tlo, a;
        bit  valid;
        o = '0;
        m_t++;
        if (!r) begin
            model_reset();
            return;
        end
        valid = (m_s2 != 0) && (m_s2 != 7);
        o.ps  = e && (m_pos == 0);
        o.pwm = e && (m_pos < m_mag);
        o.hf  = !valid;
        if (e && valid) begin
            thi = m_dir ? lo_tbl[m_s2] : hi_tbl[m_s2];
            tlo = m_dir ? hi_tbl[m_s2] : lo_tbl[m_s2];
        end else begin
            thi = -1; tlo = -1;
        end
        if (thi != m_hi || tlo != m_lo) begin
            m_hi = thi; m_lo = tlo; m_change_t = m_t;
        end
        if (m_hi >= 0 && (m_t - m_change_t) >= DT)
            o.gates = pattern(m_hi, m_lo, o.pwm, m_mag > 0);
        if (!e || m_pos == P - 1) begin
            a = (d < 0) ? -d : d;
            m_mag = (a > P) ? P : a;
            m_dir = (d < 0) ? 1 : 0;
        end
        m_pos = e ? (m_pos + 1) % P : 0;
        m_s2 = m_s1;
        m_s1 = h;
    endtask

    task automatic cycle(input bit r, input bit e, input int d, input int h);
        exp_t o;
        @(negedge CLK);
        reset      = r;
        bus.enable = e;
        bus.duty   = 24'(d);
        bus.hall   = 3'(h);
        model_step(r, e, d, h, o);
        exp_q.push_back(o);
    endtask

    task automatic run(input bit e, input int d, input int h, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, e, d, h);
    endtask

    // Monitor: one expected record per clock, compared just after the edge.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.gates, bus.pwm_out, bus.period_start, bus.hall_fault};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t gates=%b pwm=%b ps=%b hf=%b expected gates=%b pwm=%b ps=%b hf=%b",
                             $time, a.gates, a.pwm, a.ps, a.hf, e.gates, e.pwm, e.ps, e.hf);
                end
            end
        end
    end

    initial begin
        int valid_h[6] = '{5, 4, 6, 2, 3, 1};
        int d, h, n;
        bit e;
        reset = 1'b0;
        bus.enable = 1'b0;
        bus.duty = 24'd0;
        bus.hall = 3'd0;
        model_reset();
        m_t = 0;

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 0, 5);
        run(1'b1, 50, 5, 450);
        run(1'b1, 120, 5, 300);
        run(1'b1, -60, 5, 250);
        run(1'b1, 60, 5, 250);
        run(1'b1, 60, 4, 20);
        run(1'b1, 60, 6, 20);
        run(1'b1, 60, 2, 3);
        run(1'b1, 60, 3, 30);
        run(1'b1, 60, 7, 20);
        run(1'b1, 60, 2, 30);
        run(1'b1, -8388608, 2, 450);
        run(1'b1, 0, 2, 250);
        run(1'b1, 1000, 1, 250);
        run(1'b0, 80, 1, 5);
        run(1'b1, 80, 1, 100);

        // Asynchronous reset between edges with gates active.
        @(posedge CLK);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({bus.gates, bus.pwm_out, bus.period_start, bus.hall_fault} !== 9'd0) begin
            miscompares++;
            $display("FAIL async_reset gates=%b pwm=%b ps=%b hf=%b expected all 0",
                     bus.gates, bus.pwm_out, bus.period_start, bus.hall_fault);
        end
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 80, 1);
        run(1'b1, 80, 1, 60);

        for (int s = 0; s < 60; s++) begin
            case ($urandom_range(0, 5))
                0:       d = 0;
                1:       d = -8388608;
                2:       d = int'($urandom_range(0, 2 * P)) - P;
                3:       d = int'($urandom_range(0, 8388607)) * (($urandom_range(0, 1) != 0) ? -1 : 1);
                default: d = int'($urandom_range(1, P)) * (($urandom_range(0, 1) != 0) ? -1 : 1);
            endcase
            h = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) != 0) ? 7 : 0)
                                             : valid_h[$urandom_range(0, 5)];
            e = ($urandom_range(0, 19) != 0);
            n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(13, 400));
            run(e, d, h, n);
        end

        @(negedge CLK);
        @(negedge CLK);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bldc_pwm_commutator.md
Name: bldc_pwm_commutator

Overview:
Consumes the signed duty word from the position/velocity PID controller and drives the six gate signals of the three-phase half-bridge. The magnitude of duty sets the high-side PWM width and the sign sets rotation direction. Six-step commutation follows the Hall sensor inputs. Dead time is inserted on every commutation change. The block sits between the controller and the gate-driver pins.

Parameters:
PERIOD, 1000, PWM period in CLK cycles (2..65535)
DEADTIME, 8, gate-off cycles inserted on every commutation change (1..255)
CNT_W, 16, width of the period counter

Ports:
CLK  input  1  system clock
reset  input  1  asynchronous, active-low reset
enable  input  1  1 = drive bridge; 0 = all gates off, counter held
duty  input  24  signed duty from controller; |duty| in counts, sign = direction
hall  input  3  raw Hall sensors {HA_sense,HB_sense,HC_sense}, asynchronous
gates  output  6  gate drives, bit 5..0 = HA,LA,HB,LB,HC,LC
pwm_out  output  1  internal PWM waveform (high-side on-time)
period_start  output  1  one-cycle pulse when counter = 0
hall_fault  output  1  high while synchronized hall is 000 or 111

Behaviour:
- Reset (reset=0, async): gates=0, pwm_out=0, period_start=0, hall_fault=0, counter=0, mag=0, dir=0, deadtime counter=0, sync flops=0.
- Counter: runs 0..PERIOD-1 and wraps to 0. period_start=1 in the cycle the counter is 0. While enable=0, counter is held at 0 and period_start stays 0.
- Duty latch:
  - mag = min(|duty|, PERIOD) and dir = duty[23].
  - Sampled when counter=PERIOD-1; takes effect from counter=0 of the next period.
  - While enable=0, sampled every cycle.
  - duty=-2^23 yields mag=PERIOD (no overflow).
- pwm_out (registered) = 1 iff enable && counter < mag.
  - mag=0: always 0.
  - mag=PERIOD: always 1.
- Hall input: 2-flop synchronizer. The synchronized value h is used everywhere.
- Forward commutation, dir=0, h -> (PWM high phase, low phase on): 101->(A,B), 100->(A,C), 110->(B,C), 010->(B,A), 011->(C,A), 001->(C,B).
- Reverse commutation, dir=1: swap the high and low phases.
- Gate pattern:
  - The high-side gate of the selected high phase = pwm_out.
  - The low-side gate of the selected low phase = 1 whenever mag>0.
  - All other gates are 0.
  - mag=0 gives all gates 0 (coast).
- Dead time:
  - Trigger: the selected (high, low) pair differs from the pair currently applied. Causes are an h change, a dir change, or leaving fault/disable.
  - Response: gates forced to 0 for exactly DEADTIME cycles, then the new pattern is applied.
  - A further change during dead time restarts the count with the newest pair.
  - The counter and pwm_out keep running during dead time.
- Fault: h=000 or 111 sets hall_fault=1 and forces gates=0. Recovery to a valid h goes through dead time.
- enable=0: gates=0 in the next cycle. enable rising is treated as a pair change, so dead time applies.
- Latency:
  - hall pin to h: 2 cycles.
  - First dead-time cycle (gates=0) appears in the cycle after h changes.
  - All outputs are registered.
- Mid-operation reset: all outputs return to 0 immediately (async). After release, operation restarts from counter=0 with the dead-time rule applied.
- Arithmetic:
  - |duty| is computed in 24 bits, then compared against PERIOD zero-extended.
  - Counter compare is unsigned, CNT_W bits.

Test Plan:
- PERIOD=1000, enable=1, hall=101, duty=+250 -> pwm_out high 250 of every 1000 cycles; gates shows HA toggling with pwm_out, LB constant 1, others 0.
- duty changes 250->600 at counter=400 -> current period stays at 250 cycles high; next period shows 600 high, starting at counter=0.
- duty=-300 with hall=101 -> HB toggles with PWM, LA=1. Flipping sign to +300 mid-period -> 8 cycles all gates 0, then HA/LB pattern.
- hall stepped 101->100->110 -> after 2 sync cycles, 8 dead cycles precede each new pair. A second hall change 3 cycles into dead time -> count restarts, 8 cycles from the second change.
- hall=111 -> hall_fault=1, gates=0; return to 010 -> hall_fault=0, 8 dead cycles, then HB PWM with LA=1. Also check duty=-8388608 -> pwm_out constantly 1.
- Assert reset=0 mid-period with gates active -> gates, pwm_out, period_start go 0 asynchronously. Release -> counter restarts at 0 and the first gate pattern appears only after 8 dead cycles.
